// File: rtl/vga_sync_if.sv
// Raster timing bundle from vga_sync to the sprite/obstacle renderers.
// All signals describe the same pixel (x,y) in a given clock cycle.
interface vga_sync_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;

  modport master (output hsync, vsync, video_on, x, y, line_start, frame_start);
  modport slave  (input  hsync, vsync, video_on, x, y, line_start, frame_start);
endinterface

// File: rtl/vga_sync.sv
// 640x480@60 raster generator: free-running h/v counters with registered sync,
// blanking and coordinate outputs, all derived from next-count values.
module vga_sync #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  vga_sync_if.master vga_o
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_sync: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  // One spare bit keeps compares exact even when a total reaches 1024.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] x_q, x_d, y_q, y_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    x_d = (x_q == H_LAST) ? 11'd0 : x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;

    video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d       = (x_d >= HS_BEG && x_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (y_d >= VS_BEG && y_d < VS_END) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = (x_d == 11'd0);
    frame_start_d = (x_d == 11'd0) && (y_d == 11'd0);
  end

  // Reset parks on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.x           = x_q[9:0];
  assign vga_o.y           = y_q[9:0];
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.video_on    = video_on_q;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a shrunken active-high-sync raster (dut_a) and the default
// 640x480 raster (dut_d), both checked against a position-based model.
module tb_vga_sync;
  localparam int AHV = 20, AHF = 3, AHS = 5, AHB = 4, AHT = 32;
  localparam int AVV = 10, AVF = 2, AVS = 2, AVB = 3, AVT = 17;
  localparam int AFRAME = AHT * AVT;
  localparam int DHT = 800, DVT = 525;

  typedef struct packed {
    logic       hs, vs, von;
    logic [9:0] x, y;
    logic       ls, fs;
  } vout_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_sync_if ifa();
  vga_sync_if ifd();

  vga_sync #(.H_VISIBLE(AHV), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
             .V_VISIBLE(AVV), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
             .SYNC_POL(1'b1))
    dut_a (.clk(clk), .rst(rst), .vga_o(ifa.master));

  vga_sync dut_d (.clk(clk), .rst(rst), .vga_o(ifd.master));

  vout_t obs_a, obs_d;
  assign obs_a = {ifa.hsync, ifa.vsync, ifa.video_on, ifa.x, ifa.y, ifa.line_start, ifa.frame_start};
  assign obs_d = {ifd.hsync, ifd.vsync, ifd.video_on, ifd.x, ifd.y, ifd.line_start, ifd.frame_start};

  int total = 0, passed = 0;
  int k = 0;  // clock edges since reset release; 0 = in reset

  // Edge k after release shows raster position k-1, row-major, frame-periodic.
  function automatic vout_t model(int hv, int hfp, int hsw, int ht,
                                  int vv, int vfp, int vsw, int vt, bit pol, int kk);
    vout_t r;
    int p, xx, yy;
    if (kk == 0) begin
      r.hs = ~pol; r.vs = ~pol; r.von = 1'b0;
      r.x = 10'(ht - 1); r.y = 10'(vt - 1);
      r.ls = 1'b0; r.fs = 1'b0;
      return r;
    end
    p  = (kk - 1) % (ht * vt);
    xx = p % ht;
    yy = p / ht;
    r.x   = 10'(xx);
    r.y   = 10'(yy);
    r.von = (xx < hv) && (yy < vv);
    r.hs  = (xx >= hv + hfp && xx < hv + hfp + hsw) ? pol : ~pol;
    r.vs  = (yy >= vv + vfp && yy < vv + vfp + vsw) ? pol : ~pol;
    r.ls  = (xx == 0);
    r.fs  = (xx == 0) && (yy == 0);
    return r;
  endfunction

  function automatic vout_t exp_a(int kk);
    return model(AHV, AHF, AHS, AHT, AVV, AVF, AVS, AVT, 1'b1, kk);
  endfunction

  function automatic vout_t exp_d(int kk);
    return model(640, 16, 96, DHT, 480, 10, 2, DVT, 1'b0, kk);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat ($urandom_range(2, 5)) @(posedge clk);
    #1;
    k = 0;
    total++; if (obs_a !== exp_a(k)) $display("FAIL reset_hold_a got=%h want=%h", obs_a, exp_a(k)); else passed++;
    total++; if (obs_d !== exp_d(k)) $display("FAIL reset_hold_d got=%h want=%h", obs_d, exp_d(k)); else passed++;
    #($urandom_range(1, 3)) rst = 1'b0;
    tick();
    total++; if (obs_a !== exp_a(k)) $display("FAIL first_edge_a got=%h want=%h", obs_a, exp_a(k)); else passed++;
    total++; if (obs_d !== exp_d(k)) $display("FAIL first_edge_d got=%h want=%h", obs_d, exp_d(k)); else passed++;
  endtask

  task automatic test_h_sweep();
    int hs_cnt = 0, ls_cnt = 0;
    for (int i = 0; i < 2 * DHT; i++) begin
      tick();
      total++; if (obs_d !== exp_d(k)) $display("FAIL h_sweep_d k=%0d got=%h want=%h", k, obs_d, exp_d(k)); else passed++;
      total++; if (obs_a !== exp_a(k)) $display("FAIL h_sweep_a k=%0d got=%h want=%h", k, obs_a, exp_a(k)); else passed++;
      if (ifd.hsync === 1'b0) hs_cnt++;
      if (ifd.line_start === 1'b1) ls_cnt++;
    end
    total++; if (hs_cnt !== 2 * 96) $display("FAIL hsync_width got=%0d want=%0d", hs_cnt, 2 * 96); else passed++;
    total++; if (ls_cnt !== 2) $display("FAIL line_start_count_d got=%0d want=2", ls_cnt); else passed++;
  endtask

  task automatic test_frames();
    int von = 0, ls = 0, fs = 0, vs = 0, last_fs = -1;
    for (int i = 0; i < 3 * AFRAME; i++) begin
      tick();
      total++; if (obs_a !== exp_a(k)) $display("FAIL frames_a k=%0d got=%h want=%h", k, obs_a, exp_a(k)); else passed++;
      total++; if (obs_d !== exp_d(k)) $display("FAIL frames_d k=%0d got=%h want=%h", k, obs_d, exp_d(k)); else passed++;
      if (ifa.video_on === 1'b1) von++;
      if (ifa.line_start === 1'b1) ls++;
      if (ifa.vsync === 1'b1) vs++;
      if (ifa.frame_start === 1'b1) begin
        fs++;
        if (last_fs >= 0) begin
          total++; if (k - last_fs !== AFRAME) $display("FAIL frame_period got=%0d want=%0d", k - last_fs, AFRAME); else passed++;
        end
        last_fs = k;
      end
    end
    total++; if (von !== 3 * AHV * AVV) $display("FAIL video_on_count got=%0d want=%0d", von, 3 * AHV * AVV); else passed++;
    total++; if (ls !== 3 * AVT) $display("FAIL line_start_count got=%0d want=%0d", ls, 3 * AVT); else passed++;
    total++; if (fs !== 3) $display("FAIL frame_start_count got=%0d want=3", fs); else passed++;
    total++; if (vs !== 3 * AVS * AHT) $display("FAIL vsync_count got=%0d want=%0d", vs, 3 * AVS * AHT); else passed++;
  endtask

  task automatic test_mid_reset();
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(50, 3000)) begin
        tick();
        total++; if (obs_a !== exp_a(k)) $display("FAIL run_a k=%0d got=%h want=%h", k, obs_a, exp_a(k)); else passed++;
        total++; if (obs_d !== exp_d(k)) $display("FAIL run_d k=%0d got=%h want=%h", k, obs_d, exp_d(k)); else passed++;
      end
      #2 rst = 1'b1;
      #1;
      k = 0;
      total++; if (obs_a !== exp_a(k)) $display("FAIL async_reset_a got=%h want=%h", obs_a, exp_a(k)); else passed++;
      total++; if (obs_d !== exp_d(k)) $display("FAIL async_reset_d got=%h want=%h", obs_d, exp_d(k)); else passed++;
      @(posedge clk);
      #($urandom_range(1, 3)) rst = 1'b0;
      tick();
      total++; if (obs_a !== exp_a(k)) $display("FAIL restart_a got=%h want=%h", obs_a, exp_a(k)); else passed++;
      total++; if (obs_d !== exp_d(k)) $display("FAIL restart_d got=%h want=%h", obs_d, exp_d(k)); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_h_sweep();
    test_frames();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_sync.md
# vga_sync

Raster timing generator for the game's 640x480 @ 60 Hz VGA output. Clocked directly by the 25 MHz pixel clock produced by the clock divider stage. Walks a horizontal/vertical pixel counter pair and emits registered sync, blanking and pixel-coordinate signals. The sprite and obstacle renderers consume these signals to decide the colour of each pixel.

## Interface

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock (divided clock from clock divider), rising-edge
- rst  in  1  asynchronous, active-high reset
- hsync  out  1  horizontal sync, level SYNC_POL when asserted
- vsync  out  1  vertical sync, level SYNC_POL when asserted
- video_on  out  1  high while (x,y) is inside the visible area
- x  out  10  current pixel column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0

## Operation

- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be at most 1024. Elaboration-time check required.
- Horizontal counter: increments by 1 every clk. At H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on a cycle where the horizontal counter wraps. At V_TOTAL-1 it wraps to 0.
  - Both counters wrap on the same edge at (H_TOTAL-1, V_TOTAL-1) -> (0,0).
- All outputs are flops. They are computed from the next-count values so every output in a cycle describes the same (x,y). No output lags x/y.
- video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- hsync is asserted for H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC, i.e. x = 656..751.
- vsync is asserted for V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC, i.e. y = 490..491. It covers whole lines, x = 0..799.
- Deasserted sync level = ~SYNC_POL.
- No states other than the two counters. There is no enable input: the block free-runs.

## Timing

- Reset state (held while rst=1, applied asynchronously):
  - x = H_TOTAL-1 (799), y = V_TOTAL-1 (524)
  - video_on = 0, line_start = 0, frame_start = 0
  - hsync = vsync = ~SYNC_POL (inactive)
- First rising edge after rst falls: x=0, y=0, video_on=1, line_start=1, frame_start=1. Pixel (0,0) is therefore never skipped.
- Line period = 800 clk. Frame period = 420000 clk.
- line_start is high for exactly 1 clk per line. frame_start is high for exactly 1 clk per frame.
- Reset mid-frame: outputs jump to reset values immediately, without waiting for clk. Restart behaviour is identical to power-up.
- video_on is high for exactly 307200 clk per frame.
- hsync is active 96 clk per line, including during vertical blanking.

## Test plan

- Reset hold: assert rst with clk running -> x=799, y=524, hsync=vsync=1, video_on=0, pulses 0. Release rst -> next edge gives x=0, y=0, frame_start=1, line_start=1, video_on=1.
- Horizontal sweep: step through line 0 -> video_on falls at x=640, hsync falls at x=656 and rises at x=752, line_start returns at x=0 after 800 clk.
- Line wrap: at x=799, y=0 -> next edge x=0, y=1, line_start=1, frame_start=0.
- Frame wrap and vsync: run to y=489..492 -> vsync low exactly for y=490 and 491. At (799,524) -> next edge (0,0) with frame_start=1, 420000 clk after the previous frame_start.
- Counting check over 3 frames: per frame 307200 video_on cycles, 525 line_start pulses, 1 frame_start, 1600 vsync-active cycles.
- Async reset mid-frame: assert rst between edges at (x=300, y=200) -> outputs take reset values before the next edge. Release -> restart at (0,0) on the first edge.
